fetch_pc_unit: RTL
==================

Name: fetch_pc_unit

Overview:
- Instruction-fetch stage that owns the architectural PC register.
- Its redirect input is driven by the combinational next-PC logic when a branch is taken or a jump occurs.
- Issues in-order 32-bit fetch requests to instruction memory and buffers responses in a small queue with per-entry PC.
- Hands {pc, instr} pairs to decode over a valid/ready handshake; flushes cleanly on redirect, including responses still in flight.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- FQ_DEPTH, 2, fetch-queue entries (power of 2, >=2); also the maximum number of outstanding requests.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- redirect_valid  in  1  branch/jump redirect this cycle
- redirect_pc  in  64  new PC when redirect_valid
- imem_req_valid  out  1  fetch request
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  64  fetch address (= current PC)
- imem_resp_valid  in  1  response; in order, latency >=1, always accepted
- imem_resp_data  in  32  fetched instruction
- if_valid  out  1  instruction available to decode
- if_ready  in  1  decode accepts
- if_pc  out  64  PC of head entry
- if_instr  out  32  instruction of head entry
- fetch_misaligned  out  1  misaligned-redirect flag (see Optional Feature)

Behaviour:
- Reset and PC register:
  - One clock; reset is synchronous and active-high.
  - Reset values: PC=RESET_PC, queue empty (count=0), discard counter=0, imem_req_valid=0, if_valid=0, fetch_misaligned=0.
  - Reset mid-operation abandons all entries. Responses arriving after reset for pre-reset requests are not the block's concern; memory is reset together with it.
- Queue:
  - Circular, FQ_DEPTH entries of {pc, instr, filled}.
  - Issuing a request reserves the tail entry: pc=imem_req_addr, filled=0.
  - A kept response fills the oldest unfilled entry.
  - count covers both reserved and filled entries.
- Request side:
  - imem_req_valid = (count < FQ_DEPTH) && !redirect_valid. Computed from registered count only; no same-cycle pop bypass.
  - imem_req_addr = PC.
  - On handshake: PC <= PC+4 (mod 2^64) and one entry is reserved.
  - Memory must not rely on request stability: valid may drop without a handshake when a redirect arrives.
- Decode side:
  - if_valid = head entry present && head.filled; if_pc and if_instr come from the head entry.
  - Pop on if_valid && if_ready.
  - if_pc and if_instr are don't-care while if_valid=0.
- Response side:
  - When discard>0, the response is dropped and discard decrements.
  - Otherwise the response fills the oldest unfilled entry. A response with no unfilled entry cannot occur; behaviour is undefined.
- Redirect (highest priority, takes effect at the clock edge):
  - PC <= redirect_pc; queue cleared (count=0, pointers reset).
  - No pop is counted that cycle even if if_ready=1; if_valid stays as computed.
  - discard <= discard + (unfilled entries) - (1 if a response arrives this cycle and is being counted).
  - A response arriving in the redirect cycle is always dropped.
  - Back-to-back redirects: the last one wins; discard keeps accumulating correctly.
- Simultaneous events without redirect: issue, fill and pop may all occur in one cycle. count += issue - pop.
- Full queue: no request issued even if a pop occurs that cycle.
- Latency: redirect at edge N -> imem_req_addr=redirect_pc from cycle N+1. Response at edge M -> if_valid in cycle M+1 if it is the head.

Optional Feature:
- FETCH_MISALIGN_TRAP_EN defined:
  - A redirect with redirect_pc[1:0]!=0 sets fetch_misaligned=1 (sticky until rst) and loads PC.
  - All further requests are suppressed (imem_req_valid=0); queue flush and discard proceed normally.
- Not defined: fetch_misaligned is tied 0 and low address bits are not checked.

Test Plan:
- Reset, 1-cycle memory, if_ready=1 -> addresses 0,4,8,...; if_pc/if_instr pairs match in order; throughput 1 per cycle once steady.
- if_ready=0 for 5 cycles -> exactly 2 requests issued (FQ_DEPTH=2); imem_req_valid low until the first pop; no loss or duplication.
- 3-cycle memory latency, redirect to 0x1000 with 2 requests outstanding -> both stale responses dropped; first if_pc=0x1000.
- Redirect in the same cycle as a response and if_ready=1 -> response dropped, no pop counted, next if_pc=redirect target.
- PC=64'hFFFF_FFFF_FFFF_FFFC -> next request address 0 (wrap).
- With FETCH_MISALIGN_TRAP_EN, redirect_pc=0x1002 -> fetch_misaligned=1 next cycle; imem_req_valid stays 0 until rst.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch PC unit: owns the PC, issues in-order fetches and queues {pc, instr} for decode.
// Optional: define FETCH_MISALIGN_TRAP_EN to trap on misaligned redirect targets.
module fetch_pc_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr,
  output logic        fetch_misaligned
);
  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = 8;

  logic [63:0]         pc_r;
  logic [63:0]         pc_q    [FQ_DEPTH];
  logic [31:0]         instr_q [FQ_DEPTH];
  logic [FQ_DEPTH-1:0] filled_q;
  logic [PW-1:0]       head, tail, fptr;
  logic [CW-1:0]       count, ufill;
  logic [DW-1:0]       discard;
  logic                misal;
  logic                issue, pop, keep, drop;

  assign imem_req_valid = !rst && (count < CW'(FQ_DEPTH)) && !redirect_valid && !misal;
  assign imem_req_addr  = pc_r;
  assign issue          = imem_req_valid && imem_req_ready;

  assign if_valid = (count != '0) && filled_q[head];
  assign if_pc    = pc_q[head];
  assign if_instr = instr_q[head];
  assign pop      = if_valid && if_ready && !redirect_valid;

  // Stale responses owed from earlier flushes are consumed before any fill.
  assign drop = imem_resp_valid && (discard != '0);
  assign keep = imem_resp_valid && (discard == '0) && !redirect_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r     <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      fptr     <= '0;
      count    <= '0;
      ufill    <= '0;
      discard  <= '0;
      filled_q <= '0;
    end else if (redirect_valid) begin
      pc_r    <= redirect_pc;
      head    <= '0;
      tail    <= '0;
      fptr    <= '0;
      count   <= '0;
      ufill   <= '0;
      // Every unfilled entry still owes a response; one arriving now pays one debt.
      discard <= discard + DW'(ufill) - DW'(imem_resp_valid);
    end else begin
      if (issue) begin
        pc_r           <= pc_r + 64'd4;
        pc_q[tail]     <= pc_r;
        filled_q[tail] <= 1'b0;
        tail           <= tail + 1'b1;
      end
      if (keep) begin
        instr_q[fptr]  <= imem_resp_data;
        filled_q[fptr] <= 1'b1;
        fptr           <= fptr + 1'b1;
      end
      if (drop) discard <= discard - 1'b1;
      if (pop)  head    <= head + 1'b1;
      count <= count + CW'(issue) - CW'(pop);
      ufill <= ufill + CW'(issue) - CW'(keep);
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst)                                          misal <= 1'b0;
    else if (redirect_valid && redirect_pc[1:0] != 2'b00) misal <= 1'b1;
  end
`else
  assign misal = 1'b0;
`endif

  assign fetch_misaligned = misal;
endmodule
